pixel_writeback: RTL and testbench

PIXEL_WRITEBACK -- requirements
Module: pixel_writeback

---
 rtl/dither_pkg.sv | 20 ++
 rtl/pixel_writeback_if.sv | 23 ++
 rtl/raster_counter.sv | 54 +++++
 rtl/pixel_writeback.sv | 132 +++++++++++++
 tb/tb_pixel_writeback.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dither_pkg.sv
// Shared image defaults and the writeback state encoding.
package dither_pkg;

  localparam int IMAGEX     = 64;
  localparam int IMAGEY     = 64;
  localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
  localparam int RGB_SIZE   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_writeback_if.sv
// Pixel stream in, frame-RAM write port out.
// master = upstream/RAM side, slave = pixel_writeback.
interface pixel_writeback_if #(
  parameter int RGB_SIZE = dither_pkg::RGB_SIZE,
  parameter int ADDR_W   = 16
);
  logic                in_valid;
  logic [RGB_SIZE-1:0] in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [RGB_SIZE-1:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/raster_counter.sv
// Row-major x/y raster position with last-column and last-pixel flags.
module raster_counter #(
  parameter int IMAGEX = dither_pkg::IMAGEX,
  parameter int IMAGEY = dither_pkg::IMAGEY,
  parameter int XW     = dither_pkg::cnt_w(IMAGEX),
  parameter int YW     = dither_pkg::cnt_w(IMAGEY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last_col,
  output logic          last_pix
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign last_col = (x_q == XW'(IMAGEX - 1));
  assign last_pix = last_col && (y_q == YW'(IMAGEY - 1));
  assign x        = x_q;
  assign y        = y_q;

  // Next position: clear wins, otherwise step along the row and wrap into the next one
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_pix ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position register
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/pixel_writeback.sv
// Writes one frame of incoming pixels into frame RAM in row-major order.
// Optional feature: define PIXEL_WRITEBACK_ROW_DONE_EN to get a row_done
// pulse alongside each last-column write; otherwise row_done is tied low.
module pixel_writeback #(
  parameter int IMAGEX   = dither_pkg::IMAGEX,
  parameter int IMAGEY   = dither_pkg::IMAGEY,
  parameter int RGB_SIZE = dither_pkg::RGB_SIZE,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  pixel_writeback_if.slave  bus,
  output logic              busy,
  output logic              frame_done,
  output logic              row_done
);
  import dither_pkg::*;

  localparam int XW = cnt_w(IMAGEX);
  localparam int YW = cnt_w(IMAGEY);

  wb_state_e state_q, state_d;

  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic                last_col, last_pix;
  logic                clear_cnt, ready, accept;

  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [RGB_SIZE-1:0] wr_data_q, wr_data_d;

  // Only WRITE takes pixels; abort and rst shut the door in the same cycle
  always_comb begin
    ready  = (state_q == WRITE) && !abort && !rst;
    accept = bus.in_valid && ready;
  end

  assign bus.in_ready = ready;

  raster_counter #(
    .IMAGEX (IMAGEX),
    .IMAGEY (IMAGEY),
    .XW     (XW),
    .YW     (YW)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_cnt),
    .advance  (accept),
    .x        (x),
    .y        (y),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  // Frame sequencing; abort beats start, DONE lasts exactly one cycle
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = WRITE;
          clear_cnt = 1'b1;
        end
      end
      WRITE: begin
        if (abort)                  state_d = IDLE;
        else if (accept && last_pix) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register the accepted pixel as a one-cycle write; address/data hold between writes
  always_comb begin
    wr_en_d   = accept;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_addr_d = ADDR_W'(y) * ADDR_W'(IMAGEX) + ADDR_W'(x);
      wr_data_d = bus.in_data;
    end
  end

  // State and write-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = (state_q != IDLE);
  // DONE coincides with the final write, so the pulse lines up with it
  assign frame_done  = (state_q == DONE);

`ifdef PIXEL_WRITEBACK_ROW_DONE_EN
  logic row_done_q, row_done_d;

  // Mark the write of every row's last column, final row included
  always_comb row_done_d = accept && last_col;

  // Row-done register, aligned with wr_en
  always_ff @(posedge clk) begin
    if (rst) row_done_q <= 1'b0;
    else     row_done_q <= row_done_d;
  end

  assign row_done = row_done_q;
`else
  // The counter still needs last_col internally for wrapping
  logic last_col_unused;
  assign last_col_unused = last_col;
  assign row_done        = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_writeback.sv
// Directed bench for pixel_writeback on a 4x2 image with a per-cycle
// frame-level reference model and literal expectations per scenario.
module tb_pixel_writeback;

  localparam int IX = 4;
  localparam int IY = 2;
  localparam int N  = IX * IY;
  localparam int RW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, frame_done, row_done;

  pixel_writeback_if #(.RGB_SIZE(RW), .ADDR_W(AW)) bus();

  pixel_writeback #(
    .IMAGEX   (IX),
    .IMAGEY   (IY),
    .RGB_SIZE (RW),
    .ADDR_W   (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .row_done   (row_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: "active" frame, index of the next pixel, last write seen
  bit          m_active = 1'b0;
  int          m_n      = 0;
  bit          m_wr_en  = 1'b0;
  bit          m_fd     = 1'b0;
  bit          m_rd     = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [RW-1:0] m_data = '0;

  wire m_acc = m_active && bus.in_valid && !abort && !rst;

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_n      <= 0;
      m_wr_en  <= 1'b0;
      m_fd     <= 1'b0;
      m_rd     <= 1'b0;
      m_addr   <= '0;
      m_data   <= '0;
    end else begin
      m_wr_en <= m_acc;
      m_fd    <= m_acc && (m_n == N - 1);
      m_rd    <= m_acc && (m_n % IX == IX - 1);
      if (m_acc) begin
        m_addr <= AW'(m_n);
        m_data <= bus.in_data;
      end
      if (m_active) begin
        if (abort) m_active <= 1'b0;
        else if (m_acc) begin
          if (m_n == N - 1) m_active <= 1'b0;
          m_n <= m_n + 1;
        end
      end else if (start && !abort && !m_fd) begin
        m_active <= 1'b1;
        m_n      <= 0;
      end
    end
  end

  // Write log and per-cycle comparison against the model
  int wa[$];
  int wd[$];
  int wc[$];
  int rda[$];
  int fd_cnt = 0;
  int fd_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (bus.wr_en === 1'b1) begin
      wa.push_back(int'(bus.wr_addr));
      wd.push_back(int'(bus.wr_data));
      wc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (row_done === 1'b1) rda.push_back(int'(bus.wr_addr));
    if (chk_en) begin
      chk("in_ready", bus.in_ready, m_active && !abort && !rst);
      chk("wr_en", bus.wr_en, m_wr_en);
      chk("busy", busy, m_active || m_fd);
      chk("frame_done", frame_done, m_fd);
`ifdef PIXEL_WRITEBACK_ROW_DONE_EN
      chk("row_done", row_done, m_rd);
`else
      chk("row_done", row_done, 0);
`endif
      if (m_wr_en) begin
        chk("wr_addr", bus.wr_addr, m_addr);
        chk("wr_data", bus.wr_data, m_data);
      end
    end
  end

  task automatic drive(input bit s, input bit a, input bit v, input logic [RW-1:0] d);
    start        = s;
    abort        = a;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int b, f0, r0, b2;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);

    // Full frame; the start cycle offers a pixel that must not be taken
    b = wa.size(); f0 = fd_cnt; r0 = rda.size();
    drive(1'b1, 1'b0, 1'b1, 8'hEE);
    for (int k = 0; k < N; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'hA0 + k));
    idle(3);
    chk("s1_writes", wa.size() - b, 8);
    for (int i = 0; i < N; i++) begin
      chk("s1_addr", wa[b + i], i);
      chk("s1_data", wd[b + i], 32'hA0 + i);
    end
    chk("s1_fd_count", fd_cnt - f0, 1);
    chk("s1_fd_on_8th_write", fd_cyc, wc[b + 7]);
`ifdef PIXEL_WRITEBACK_ROW_DONE_EN
    chk("s1_row_count", rda.size() - r0, 2);
    chk("s1_row_addr0", rda[r0], 3);
    chk("s1_row_addr1", rda[r0 + 1], 7);
`else
    chk("s1_row_count", rda.size() - r0, 0);
`endif

    // Stall: three idle cycles after the 2nd pixel
    b = wa.size(); f0 = fd_cnt;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + k));
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 8'h55);
    for (int k = 2; k < N; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h10 + k));
    idle(3);
    chk("s2_writes", wa.size() - b, 8);
    chk("s2_third_addr", wa[b + 2], 2);
    chk("s2_third_data", wd[b + 2], 32'h12);
    chk("s2_gap_cycles", wc[b + 2] - wc[b + 1], 4);
    chk("s2_fd_count", fd_cnt - f0, 1);

    // Abort after 5 pixels, then a fresh frame from address 0
    b = wa.size(); f0 = fd_cnt;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h30 + k));
    drive(1'b0, 1'b1, 1'b1, 8'h77);
    chk("s3_busy_after_abort", busy, 0);
    idle(3);
    chk("s3_writes", wa.size() - b, 5);
    chk("s3_fd_count", fd_cnt - f0, 0);
    b2 = wa.size(); f0 = fd_cnt;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < N; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + k));
    idle(3);
    chk("s3_restart_writes", wa.size() - b2, 8);
    chk("s3_restart_addr0", wa[b2], 0);
    chk("s3_restart_data0", wd[b2], 32'h40);
    chk("s3_restart_fd", fd_cnt - f0, 1);

    // start during WRITE ignored; start+abort in IDLE ignored
    b = wa.size();
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 8'h60);
    drive(1'b1, 1'b0, 1'b1, 8'h61);
    for (int k = 2; k < N; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h60 + k));
    idle(3);
    chk("s4_writes", wa.size() - b, 8);
    for (int i = 0; i < N; i++) chk("s4_addr", wa[b + i], i);
    drive(1'b1, 1'b1, 1'b1, 8'h99);
    chk("s4_busy_start_abort", busy, 0);
    drive(1'b0, 1'b0, 1'b1, 8'h9A);
    drive(1'b0, 1'b0, 1'b1, 8'h9B);
    chk("s4_still_idle", busy, 0);
    chk("s4_no_writes", wa.size() - b, 8);

    // rst on the cycle after the 3rd acceptance, with start and abort also high
    b = wa.size(); f0 = fd_cnt;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 8'(8'h70 + k));
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h7F);
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_wr_en", bus.wr_en, 0);
    chk("s5_in_ready", bus.in_ready, 0);
    chk("s5_frame_done", frame_done, 0);
    chk("s5_row_done", row_done, 0);
    chk("s5_wr_addr", bus.wr_addr, 0);
    chk("s5_wr_data", bus.wr_data, 0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 8'h7E);
    chk("s5_writes", wa.size() - b, 3);
    chk("s5_fd_count", fd_cnt - f0, 0);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
